// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I-subset core: sequences fetch, decode,
// execute, memory and writeback, and drives the ALU op code and datapath selects.
module multicycle_control #(
    parameter bit FETCH_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] operation_control,
    output logic       illegal_instr
);

    typedef enum logic [3:0] {
        S_HALT, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    state_t state;
    logic   alu_f3_ok;
    logic [2:0] alu_op_dec;

    assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);

    always_comb begin
        case (funct3)
            3'b000:  alu_op_dec = (state == S_EXECR && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b110:  alu_op_dec = ALU_OR;
            3'b111:  alu_op_dec = ALU_AND;
            default: alu_op_dec = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH_ON_RESET ? S_FETCH : S_HALT;
        end else begin
            case (state)
                S_HALT:     if (start) state <= S_FETCH;
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:          state <= alu_f3_ok ? S_EXECR : S_TRAP;
                        OP_ITYPE:          state <= alu_f3_ok ? S_EXECI : S_TRAP;
                        OP_BEQ:            state <= (funct3 == 3'b000) ? S_BEQ : S_TRAP;
                        OP_JAL:            state <= S_JAL;
                        default:           state <= S_TRAP;
                    endcase
                end
                // Loads and stores differ only in opcode bit 5; the IR still holds it here.
                S_MEMADR:   state <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECR,
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB,
                S_BEQ,
                S_JAL:      state <= S_FETCH;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_TRAP;
            endcase
        end
    end

    always_comb begin
        mem_req           = 1'b0;
        mem_write         = 1'b0;
        adr_src           = 1'b0;
        ir_write          = 1'b0;
        pc_write          = 1'b0;
        reg_write         = 1'b0;
        alu_src_a         = 2'b00;
        alu_src_b         = 2'b00;
        result_src        = 2'b00;
        operation_control = ALU_ADD;
        illegal_instr     = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a         = 2'b10;
                    operation_control = alu_op_dec;
                end
                S_EXECI: begin
                    alu_src_a         = 2'b10;
                    alu_src_b         = 2'b01;
                    operation_control = alu_op_dec;
                end
                S_ALUWB:   reg_write = 1'b1;
                S_BEQ: begin
                    alu_src_a         = 2'b10;
                    operation_control = ALU_SUB;
                    pc_write          = zero;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                    reg_write = 1'b1;
                end
                S_TRAP:    illegal_instr = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: each driven cycle queues the
// expected control word derived from the instruction's sequencing rules.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] operation_control;
    logic       illegal_instr;

    multicycle_control #(.FETCH_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .operation_control(operation_control),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b110;
    localparam logic [2:0] OR_ = 3'b001;
    localparam logic [2:0] AND_ = 3'b000;

    logic [15:0] exp_q[$];
    string       tag_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [15:0] act;

    assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, result_src, operation_control, illegal_instr};

    function automatic logic [15:0] ov(input logic req, input logic wr, input logic adr,
                                       input logic ir, input logic pc, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] rs, input logic [2:0] op,
                                       input logic ill);
        return {req, wr, adr, ir, pc, rw, a, b, rs, op, ill};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: one expected control word per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s: got %b required %b", t, act, e);
            end
        end
    end

    task automatic cyc(input logic rst, input logic mr, input logic z,
                       input logic [15:0] e, input string t);
        reset = rst;
        mem_ready = mr;
        zero = z;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, rb(), rb(), ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,ADD,0), "RESET");
    endtask

    function automatic logic f3_alu_legal(input logic [2:0] f3);
        return f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd7;
    endfunction

    function automatic logic [2:0] alu_model(input logic is_r, input logic [2:0] f3,
                                             input logic f75);
        if (f3 == 3'd6) return OR_;
        if (f3 == 3'd7) return AND_;
        return (is_r && f75) ? SUB : ADD;
    endfunction

    // Runs one instruction from FETCH; leaves the DUT back in FETCH.
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                             input logic z, input int unsigned fst, input int unsigned mst,
                             input bit rst_store, input int unsigned hold);
        logic is_mem, is_r, is_i, legal;
        opcode = opc;
        funct3 = f3;
        funct7_5 = f75;
        for (int unsigned i = 0; i < fst; i++)
            cyc(0, 0, rb(), ov(1,0,0,0,0,0,2'b00,2'b10,2'b10,ADD,0), "FETCH_WAIT");
        cyc(0, 1, rb(), ov(1,0,0,1,1,0,2'b00,2'b10,2'b10,ADD,0), "FETCH");
        cyc(0, rb(), rb(), ov(0,0,0,0,0,0,2'b01,2'b01,2'b00,ADD,0), "DECODE");
        is_mem = (opc == 7'b0000011) || (opc == 7'b0100011);
        is_r = (opc == 7'b0110011);
        is_i = (opc == 7'b0010011);
        legal = is_mem || opc == 7'b1101111 || ((is_r || is_i) && f3_alu_legal(f3))
                || (opc == 7'b1100011 && f3 == 3'd0);
        if (!legal) begin
            for (int unsigned i = 0; i < hold; i++)
                cyc(0, rb(), rb(), ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,ADD,1), "TRAP");
            do_reset();
        end else if (is_mem) begin
            cyc(0, rb(), rb(), ov(0,0,0,0,0,0,2'b10,2'b01,2'b00,ADD,0), "MEMADR");
            if (opc == 7'b0000011) begin
                for (int unsigned i = 0; i < mst; i++)
                    cyc(0, 0, rb(), ov(1,0,1,0,0,0,2'b00,2'b00,2'b00,ADD,0), "MEMREAD_WAIT");
                cyc(0, 1, rb(), ov(1,0,1,0,0,0,2'b00,2'b00,2'b00,ADD,0), "MEMREAD");
                cyc(0, rb(), rb(), ov(0,0,0,0,0,1,2'b00,2'b00,2'b01,ADD,0), "MEMWB");
            end else begin
                for (int unsigned i = 0; i < mst; i++)
                    cyc(0, 0, rb(), ov(1,1,1,0,0,0,2'b00,2'b00,2'b00,ADD,0), "MEMWRITE_WAIT");
                if (rst_store)
                    do_reset();
                else
                    cyc(0, 1, rb(), ov(1,1,1,0,0,0,2'b00,2'b00,2'b00,ADD,0), "MEMWRITE");
            end
        end else if (is_r || is_i) begin
            cyc(0, rb(), rb(), ov(0,0,0,0,0,0,2'b10, is_i ? 2'b01 : 2'b00, 2'b00,
                                  alu_model(is_r, f3, f75), 0), is_r ? "EXECR" : "EXECI");
            cyc(0, rb(), rb(), ov(0,0,0,0,0,1,2'b00,2'b00,2'b00,ADD,0), "ALUWB");
        end else if (opc == 7'b1100011) begin
            cyc(0, rb(), z, ov(0,0,0,0,z,0,2'b10,2'b00,2'b00,SUB,0), "BEQ");
        end else begin
            cyc(0, rb(), rb(), ov(0,0,0,0,1,1,2'b01,2'b10,2'b00,ADD,0), "JAL");
        end
    endtask

    logic [6:0] bad_ops [7] = '{7'b0110111, 7'b0010111, 7'b1100111, 7'b1110011,
                                7'b0001111, 7'b0000000, 7'b1111111};

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0, 0, 0);   // add
        run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0, 0, 0);   // sub
        run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0, 0, 0);   // addi, f7_5 ignored
        run_instr(7'b0010011, 3'd6, 1'b0, 1'b0, 1, 0, 0, 0);   // ori
        run_instr(7'b0010011, 3'd7, 1'b0, 1'b0, 0, 0, 0, 0);   // andi
        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 0, 3, 0, 0);   // lw, 3 stall cycles
        run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 2, 1, 0);   // sw aborted by reset
        run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 1, 0, 0);   // sw
        run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0, 0, 0);   // beq taken
        run_instr(7'b1100011, 3'd0, 1'b0, 1'b0, 0, 0, 0, 0);   // beq not taken
        run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0, 0, 2);   // bne -> trap
        run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 0, 0, 0, 0);   // jal
        run_instr(7'b0110111, 3'd0, 1'b0, 1'b0, 0, 0, 0, 10);  // lui -> trap 10 cycles
        for (int i = 0; i < 200; i++) begin
            int unsigned k;
            logic [2:0] f3;
            k = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 7));
            case (k)
                0, 1: run_instr(7'b0110011, f3, rb(), rb(), $urandom_range(0, 2), 0, 0,
                                $urandom_range(1, 4));
                2, 3: run_instr(7'b0010011, f3, rb(), rb(), $urandom_range(0, 2), 0, 0,
                                $urandom_range(1, 4));
                4:    run_instr(7'b0000011, f3, rb(), rb(), $urandom_range(0, 2),
                                $urandom_range(0, 4), 0, 0);
                5:    run_instr(7'b0100011, f3, rb(), rb(), $urandom_range(0, 2),
                                $urandom_range(0, 4), ($urandom_range(0, 3) == 0), 0);
                6, 7: run_instr(7'b1100011, ($urandom_range(0, 3) == 0) ? f3 : 3'd0, rb(),
                                rb(), $urandom_range(0, 2), 0, 0, $urandom_range(1, 4));
                8:    run_instr(7'b1101111, f3, rb(), rb(), $urandom_range(0, 2), 0, 0, 0);
                default: run_instr(bad_ops[$urandom_range(0, 6)], f3, rb(), rb(),
                                   $urandom_range(0, 2), 0, 0, $urandom_range(1, 10));
            endcase
        end
        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
